// File: rtl/cam_pkg.sv
// Shared types and helpers for the OV7670 capture path: state encoding,
// pixel format and the RGB565 -> RGB444 reduction.
package cam_pkg;

  typedef enum logic [1:0] {IDLE, ARM, SYNC, ACTIVE} cap_state_t;

  typedef logic [11:0] rgb444_t;

  localparam int VGA_W  = 640;
  localparam int VGA_H  = 480;
  localparam int QVGA_W = 320;
  localparam int QVGA_H = 240;

  // Line/column counters and the decimation phase counters.
  localparam int CNT_W = 10;
  localparam int MOD_W = 3;

  // Keep the top nibble of each RGB565 channel; first byte is {R5,G[5:3]}.
  function automatic rgb444_t rgb565_to_444(input logic [7:0] b0, input logic [7:0] b1);
    return {b0[7:4], b0[2:0], b1[7], b1[4:1]};
  endfunction

endpackage

// File: rtl/cam_capture.sv
// Camera pixel-clock capture: pairs bus bytes into RGB444 pixels, decimates the
// frame and streams sequential writes into the frame buffer.
module cam_capture
  import cam_pkg::*;
#(
  parameter int SRC_W  = VGA_W,
  parameter int SRC_H  = VGA_H,
  parameter int H_DEC  = 2,
  parameter int V_DEC  = 2,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = QVGA_W * QVGA_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output rgb444_t           data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam logic [CNT_W-1:0]  SRC_W_C = CNT_W'(SRC_W);
  localparam logic [CNT_W-1:0]  SRC_H_C = CNT_W'(SRC_H);
  localparam logic [MOD_W-1:0]  H_LAST  = MOD_W'(H_DEC - 1);
  localparam logic [MOD_W-1:0]  V_LAST  = MOD_W'(V_DEC - 1);
  localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(DEPTH);

  cap_state_t        state_q, state_d;
  logic              vsync_q, vsync_q2, href_q, href_q2;
  logic [7:0]        d_q, b0_q;
  logic              phase_q;
  logic [CNT_W-1:0]  col_q, row_q;
  logic [MOD_W-1:0]  hmod_q, vmod_q;
  logic              we_q, busy_q, fdone_q, ovf_q;
  logic [ADDR_W-1:0] addr_q;
  rgb444_t           data_q;

  logic vs_rise, vs_fall, href_fall, pix_done, store_due, start_frame;

  assign vs_rise     = vsync_q & ~vsync_q2;
  assign vs_fall     = ~vsync_q & vsync_q2;
  assign href_fall   = ~href_q & href_q2;
  assign pix_done    = (state_q == ACTIVE) && href_q && phase_q;
  assign store_due   = pix_done && (hmod_q == '0) && (vmod_q == '0) &&
                       (col_q < SRC_W_C) && (row_q < SRC_H_C);
  assign start_frame = (state_q == SYNC) && (state_d == ACTIVE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture_en) state_d = ARM;
      ARM:     if (!capture_en) state_d = IDLE;
               else if (vsync_q) state_d = SYNC;
      SYNC:    if (!capture_en) state_d = IDLE;
               else if (vs_fall) state_d = ACTIVE;
      ACTIVE:  if (vs_rise) state_d = capture_en ? SYNC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      vsync_q  <= 1'b0;
      vsync_q2 <= 1'b0;
      href_q   <= 1'b0;
      href_q2  <= 1'b0;
      d_q      <= '0;
      b0_q     <= '0;
      phase_q  <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      hmod_q   <= '0;
      vmod_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      fdone_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      // d rides the same single register stage as the sync strobes.
      vsync_q  <= vsync;
      vsync_q2 <= vsync_q;
      href_q   <= href;
      href_q2  <= href_q;
      d_q      <= d;

      state_q <= state_d;
      busy_q  <= (state_d == SYNC) || (state_d == ACTIVE);
      fdone_q <= (state_q == ACTIVE) && vs_rise;

      we_q <= store_due && (addr_q != DEPTH_C);
      if (store_due && (addr_q != DEPTH_C)) data_q <= rgb565_to_444(b0_q, d_q);

      if ((state_q == IDLE) && (state_d == ARM)) ovf_q <= 1'b0;
      else if (store_due && (addr_q == DEPTH_C)) ovf_q <= 1'b1;

      // addr shows the slot being written while we is high, then advances.
      if (start_frame) addr_q <= '0;
      else if (we_q)   addr_q <= addr_q + 1'b1;

      if ((state_q == ACTIVE) && href_q) begin
        phase_q <= ~phase_q;
        if (!phase_q) b0_q <= d_q;
      end else begin
        phase_q <= 1'b0;
      end

      if (!href_q) begin
        col_q  <= '0;
        hmod_q <= '0;
      end else if (pix_done) begin
        if (col_q != '1) col_q <= col_q + 1'b1;
        hmod_q <= (hmod_q == H_LAST) ? '0 : hmod_q + 1'b1;
      end

      // Saturating row count: lines past the source height are simply dropped.
      if (start_frame) begin
        row_q  <= '0;
        vmod_q <= '0;
      end else if ((state_q == ACTIVE) && href_fall) begin
        if (row_q != '1) row_q <= row_q + 1'b1;
        vmod_q <= (vmod_q == V_LAST) ? '0 : vmod_q + 1'b1;
      end
    end
  end

  assign we         = we_q;
  assign addr       = addr_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign overflow   = ovf_q;

endmodule
